rx_multimode_flex_counter: RTL and testbench
============================================

// Module: rx_multimode_flex_counter
// PURPOSE
//  Parametrised multi-mode successor to the USB RX flex counter.
//  - Up/down counting, four wrap modes (legacy wrap-to-1, wrap-to-0, saturate, one-shot).
//  - Synchronous load and a built-in enable prescaler.
//  - Used by RX bit-timing (clocks per bit, prescaled) and byte/packet counters (one-shot).
// PARAMETERS
//  NUM_CNT_BITS   4  width of count_out, load_val, rollover_val
//  PRESCALE_BITS  4  width of prescale_val and the internal prescaler counter
// PORTS
//  clk            in   1              clock, rising edge
//  n_rst          in   1              reset, asynchronous, active-low
//  clear          in   1              synchronous clear, highest synchronous priority
//  count_enable   in   1              enable for the prescaler and count
//  up_down        in   1              1 = count up, 0 = count down
//  load           in   1              synchronous load of load_val
//  load_val       in   NUM_CNT_BITS   value loaded when load=1
//  rollover_val   in   NUM_CNT_BITS   upper bound R of the count range
//  wrap_mode      in   2              00 WRAP1, 01 WRAP0, 10 SAT, 11 ONESHOT
//  prescale_val   in   PRESCALE_BITS  P; a step occurs every P+1 enabled cycles
//  count_out      out  NUM_CNT_BITS   current count (registered)
//  rollover_flag  out  1              count_out == terminal (registered level)
//  rollover_pulse out  1              1-cycle pulse when a step lands on terminal
//  step           out  1              combinational: a count step occurs this cycle
//  done           out  1              ONESHOT reached terminal; counter stopped
// BEHAVIOUR
//  Reset: all outputs and the prescaler counter go to 0.
//  Range base W:
//   - W = 1 in WRAP1; W = 0 in all other modes.
//  Terminal T:
//   - Up: T = R.
//   - Down: T = W.
//  Restart value S:
//   - Up: S = W.
//   - Down: S = R.
//  Synchronous priority: clear > load > step.
//   - clear: count, prescaler, flag, pulse and done all go to 0.
//   - load: count = load_val; prescaler = 0; done = 0; pulse = 0;
//     flag = (load_val == T).
//  Prescaler pcnt:
//   - When count_enable=1 and not stopped: if pcnt == P, step=1 and pcnt=0;
//     otherwise pcnt increments.
//   - P=0: step occurs on every enabled cycle (legacy timing).
//   - count_enable=0: pcnt and count hold.
//  Stopped when any of:
//   - wrap_mode == ONESHOT and done=1.
//   - R < W (invalid range; includes R=0).
//   While stopped: step=0; count and pcnt hold.
//  At terminal: up with count_out >= R, or down with count_out <= W.
//   - Out-of-range counts (loaded, or R changed) therefore converge.
//  Step, not at terminal: count +1 (up) or -1 (down).
//  Step, at terminal:
//   - WRAP1/WRAP0: count = S.
//   - SAT: count holds.
//   - ONESHOT: count holds and done=1.
//  rollover_flag:
//   - Registered as (next count == T); updated on every count update, clear or load.
//   - SAT: stays high at terminal.
//  rollover_pulse:
//   - High for exactly the one cycle after a step whose next count == T.
//   - SAT: re-asserts on each step taken while held at terminal.
//   - ONESHOT: single pulse.
//   - Never asserted by load or clear.
//  Latency: one clock from a step to count_out, flag and pulse.
//   - step is combinational in the same cycle.
//  Arithmetic is modulo 2^NUM_CNT_BITS. Terminal detection prevents wrap in range.
//  Mode or direction change mid-count:
//   - Takes effect on the next step.
//   - No reset of count or prescaler.
//  Asynchronous reset mid-count: immediate return to the reset state.
//   - Counting resumes from 0 on the first enabled cycle after release.
//  Bit-exact equivalence: WRAP1, up, P=0 matches the legacy RX flex counter.
// TESTING
//  1. Legacy: WRAP1, up, R=5, P=0, enable held.
//     -> count 1,2,3,4,5,1,2...
//     -> flag high only at 5; pulse 1 cycle at each 5.
//  2. Prescale: P=3, WRAP0, up, R=2, enable held.
//     -> count advances every 4th cycle: 0,1,2,0.
//     -> step high 1 of every 4 cycles.
//     -> enable dropped 2 cycles mid-period: period stretches by 2.
//  3. Down/SAT: load_val=3, up_down=0, SAT, R=9.
//     -> count 3,2,1,0,0,0...
//     -> flag stays 1 at 0; pulse on each step at 0.
//  4. ONESHOT: up, R=4, from clear.
//     -> count 1..4, done=1, single pulse.
//     -> count frozen with enable high; load 0 restarts and drops done.
//  5. Priority and edges:
//     -> clear+load+step in the same cycle: count=0.
//     -> load 12 with R=7 up WRAP0: next step gives 0.
//     -> R=0 in WRAP1: count frozen, step=0.
//  6. Async reset: n_rst low mid-count at 6, asserted between edges.
//     -> all outputs 0 immediately.
//     -> after release, first step gives count=1.

Source files
------------

// File: rtl/rx_multimode_flex_counter.sv
// Multi-mode RX flex counter: up/down, four wrap modes,
// synchronous load and an enable prescaler.
module rx_multimode_flex_counter #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     count_enable,
  input  logic                     up_down,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  input  logic [1:0]               wrap_mode,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     rollover_pulse,
  output logic                     step,
  output logic                     done
);

  localparam logic [1:0] M_WRAP1   = 2'b00;
  localparam logic [1:0] M_WRAP0   = 2'b01;
  localparam logic [1:0] M_SAT     = 2'b10;
  localparam logic [1:0] M_ONESHOT = 2'b11;

  logic [NUM_CNT_BITS-1:0]  count_q, count_d;
  logic [PRESCALE_BITS-1:0] pcnt_q, pcnt_d;
  logic flag_q, flag_d;
  logic pulse_q, pulse_d;
  logic done_q, done_d;

  logic [NUM_CNT_BITS-1:0] base;
  logic [NUM_CNT_BITS-1:0] term_val;
  logic [NUM_CNT_BITS-1:0] restart;
  logic stopped;
  logic at_term;
  logic run;
  logic step_c;

  // Range decode, stop condition and prescaler tick
  always_comb begin
    base     = (wrap_mode == M_WRAP1) ? NUM_CNT_BITS'(1) : '0;
    term_val = up_down ? rollover_val : base;
    restart  = up_down ? base : rollover_val;
    stopped  = ((wrap_mode == M_ONESHOT) && done_q) ||
               (rollover_val < base);
    at_term  = up_down ? (count_q >= rollover_val) :
                         (count_q <= base);
    run      = n_rst && count_enable && !stopped;
    step_c   = run && (pcnt_q == prescale_val);
  end

  assign step = step_c;

  // Next-state: clear beats load beats step
  always_comb begin
    count_d = count_q;
    pcnt_d  = pcnt_q;
    flag_d  = flag_q;
    pulse_d = 1'b0;
    done_d  = done_q;
    if (clear) begin
      count_d = '0;
      pcnt_d  = '0;
      flag_d  = 1'b0;
      done_d  = 1'b0;
    end else if (load) begin
      count_d = load_val;
      pcnt_d  = '0;
      done_d  = 1'b0;
      flag_d  = (load_val == term_val);
    end else begin
      if (run) begin
        pcnt_d = step_c ? '0 : pcnt_q + PRESCALE_BITS'(1);
      end
      if (step_c) begin
        if (!at_term) begin
          count_d = up_down ? count_q + NUM_CNT_BITS'(1) :
                              count_q - NUM_CNT_BITS'(1);
        end else begin
          unique case (wrap_mode)
            M_WRAP1, M_WRAP0: count_d = restart;
            M_SAT:            count_d = count_q;
            M_ONESHOT:        done_d  = 1'b1;
            default:          count_d = count_q;
          endcase
        end
        flag_d  = (count_d == term_val);
        // the one-shot stop step holds at terminal without a second pulse
        pulse_d = (count_d == term_val) &&
                  !((wrap_mode == M_ONESHOT) && at_term);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      pcnt_q  <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  assign count_out      = count_q;
  assign rollover_flag  = flag_q;
  assign rollover_pulse = pulse_q;
  assign done           = done_q;

endmodule

// File: tb/tb_rx_multimode_flex_counter.sv
// Directed bench for rx_multimode_flex_counter with a
// reference model feeding a scoreboard queue.
module tb_rx_multimode_flex_counter;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clear;
  logic       count_enable;
  logic       up_down;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] rollover_val;
  logic [1:0] wrap_mode;
  logic [3:0] prescale_val;
  logic [3:0] count_out;
  logic       rollover_flag;
  logic       rollover_pulse;
  logic       step;
  logic       done;

  rx_multimode_flex_counter #(
    .NUM_CNT_BITS(4),
    .PRESCALE_BITS(4)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .clear(clear),
    .count_enable(count_enable),
    .up_down(up_down),
    .load(load),
    .load_val(load_val),
    .rollover_val(rollover_val),
    .wrap_mode(wrap_mode),
    .prescale_val(prescale_val),
    .count_out(count_out),
    .rollover_flag(rollover_flag),
    .rollover_pulse(rollover_pulse),
    .step(step),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] c;
    logic       f;
    logic       p;
    logic       d;
  } exp_t;

  exp_t q[$];
  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] m_c, m_p;
  logic       m_f, m_pl, m_d;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_c = 0; m_p = 0; m_f = 0; m_pl = 0; m_d = 0;
  endtask

  // One clock: predict, push, advance, pop and compare.
  task automatic tick();
    logic [3:0] w, t;
    logic stop, ms, term;
    exp_t e;
    #2;
    w    = (wrap_mode == 2'd0) ? 4'd1 : 4'd0;
    t    = up_down ? rollover_val : w;
    stop = ((wrap_mode == 2'd3) && m_d) || (rollover_val < w);
    ms   = n_rst && count_enable && !stop && (m_p == prescale_val);
    chk("step", {7'd0, step}, {7'd0, ms});
    if (clear) begin
      model_reset();
    end else if (load) begin
      m_c = load_val; m_p = 0; m_d = 0; m_pl = 0;
      m_f = (load_val == t);
    end else begin
      m_pl = 0;
      if (count_enable && !stop) m_p = ms ? 4'd0 : m_p + 4'd1;
      if (ms) begin
        term = up_down ? (m_c >= rollover_val) : (m_c <= w);
        if (!term) m_c = up_down ? m_c + 4'd1 : m_c - 4'd1;
        else if (wrap_mode <= 2'd1) m_c = up_down ? w : rollover_val;
        else if (wrap_mode == 2'd3) m_d = 1'b1;
        m_f  = (m_c == t);
        m_pl = (m_c == t) && !((wrap_mode == 2'd3) && term);
      end
    end
    e = '{c: m_c, f: m_f, p: m_pl, d: m_d};
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("count", {4'd0, count_out}, {4'd0, e.c});
    chk("flag", {7'd0, rollover_flag}, {7'd0, e.f});
    chk("pulse", {7'd0, rollover_pulse}, {7'd0, e.p});
    chk("done", {7'd0, done}, {7'd0, e.d});
  endtask

  task automatic do_clear();
    clear = 1; tick(); clear = 0;
  endtask

  initial begin
    logic [3:0] leg [7];
    logic [3:0] c0;
    int np;
    leg = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2};
    n_rst = 0; clear = 0; count_enable = 0; up_down = 1;
    load = 0; load_val = 0; rollover_val = 5;
    wrap_mode = 2'd0; prescale_val = 0;
    model_reset();
    #12;
    chk("rst_count", {4'd0, count_out}, 8'd0);
    chk("rst_outs", {4'd0, rollover_flag, rollover_pulse, step, done}, 8'd0);
    @(posedge clk); #1;
    n_rst = 1;

    // legacy WRAP1 up R=5 P=0
    count_enable = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("leg_cnt", {4'd0, count_out}, {4'd0, leg[i]});
      chk("leg_flag", {7'd0, rollover_flag}, {7'd0, leg[i] == 4'd5});
      chk("leg_pulse", {7'd0, rollover_pulse}, {7'd0, leg[i] == 4'd5});
    end

    // prescale P=3 WRAP0 R=2
    count_enable = 0; wrap_mode = 2'd1; rollover_val = 2;
    prescale_val = 3;
    do_clear();
    count_enable = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("pre_cnt", {4'd0, count_out}, 8'(((i + 1) / 4) % 3));
    end
    tick(); tick();
    count_enable = 0; tick(); tick();
    count_enable = 1; tick();
    chk("stretch_hold", {4'd0, count_out}, 8'd0);
    tick();
    chk("stretch_step", {4'd0, count_out}, 8'd1);

    // down SAT from load 3, R=9
    prescale_val = 0; wrap_mode = 2'd2; up_down = 0;
    rollover_val = 9; load_val = 3; count_enable = 0;
    load = 1; tick(); load = 0;
    chk("sat_load", {4'd0, count_out}, 8'd3);
    count_enable = 1;
    for (int i = 0; i < 6; i++) tick();
    chk("sat_cnt", {4'd0, count_out}, 8'd0);
    chk("sat_flag", {7'd0, rollover_flag}, 8'd1);
    chk("sat_pulse", {7'd0, rollover_pulse}, 8'd1);

    // ONESHOT up R=4
    up_down = 1; wrap_mode = 2'd3; rollover_val = 4;
    count_enable = 0;
    do_clear();
    count_enable = 1;
    np = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      np += int'(rollover_pulse);
    end
    chk("os_cnt", {4'd0, count_out}, 8'd4);
    chk("os_done", {7'd0, done}, 8'd1);
    chk("os_npulse", 8'(np), 8'd1);
    load_val = 0; load = 1; tick(); load = 0;
    chk("os_reload", {4'd0, count_out, 3'd0, done}, 8'd0);
    tick();
    chk("os_restart", {4'd0, count_out}, 8'd1);

    // priority: clear+load+step
    wrap_mode = 2'd1; rollover_val = 7; load_val = 12;
    clear = 1; load = 1; tick(); clear = 0; load = 0;
    chk("prio", {4'd0, count_out}, 8'd0);
    load = 1; tick(); load = 0;
    chk("oor_load", {4'd0, count_out}, 8'd12);
    tick();
    chk("oor_step", {4'd0, count_out}, 8'd0);
    // R=0 in WRAP1 freezes
    wrap_mode = 2'd0; rollover_val = 0;
    c0 = count_out;
    tick(); tick();
    chk("r0_frozen", {4'd0, count_out}, {4'd0, c0});

    // async reset at count 6
    wrap_mode = 2'd1; rollover_val = 9;
    do_clear();
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst", {4'd0, count_out}, 8'd6);
    #2; n_rst = 0; #1;
    chk("arst_cnt", {4'd0, count_out}, 8'd0);
    chk("arst_outs", {4'd0, rollover_flag, rollover_pulse, step, done}, 8'd0);
    model_reset();
    @(posedge clk); #1;
    n_rst = 1;
    tick();
    chk("post_rst", {4'd0, count_out}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
